// File: rtl/probe_ts_stamp.sv
// probe_ts_stamp: ingress writer of the RTT probe timestamp word.
//
// After the module headers of a packet have passed, inserts one 64-bit word
// {16'h0, seq[15:0], ts[31:0]} ahead of the first payload word. It also bumps the
// IOQ header word length by 1 and byte length by 8 so downstream sees a
// consistent length. Stamping is decided once per packet, when the IOQ header
// is accepted.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_data/in_ctrl     input word / ctrl, written when in_wr=1
//   in_rdy              input FIFO has room (not nearly full)
//   out_data/out_ctrl   output word / ctrl, valid when out_wr=1
//   out_rdy             downstream ready; out_wr is only raised when out_rdy=1
//   stamp_en            stamping enable, sampled at IOQ header acceptance
//   ts_now              free-running timestamp (one tick every TS_DIV cycles)
module probe_ts_stamp #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TS_DIV     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  stamp_en,
  output logic [31:0]           ts_now
);

  localparam int unsigned FifoWidth     = CTRL_WIDTH + DATA_WIDTH;
  localparam int unsigned FifoDepth     = 4;
  localparam int unsigned IoqWordLenPos = 48;
  localparam int unsigned IoqByteLenPos = 0;
  localparam logic [CTRL_WIDTH-1:0] IoQueueStageNum = CTRL_WIDTH'(8'hff);

  typedef enum logic [0:0] {StHdrs, StThru} state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO: 4 entries, first-word fallthrough (head visible when non-empty).
  // ---------------------------------------------------------------------------
  logic [FifoWidth-1:0] fifo_mem [FifoDepth];
  logic [1:0]           wr_ptr_q, rd_ptr_q;
  logic [2:0]           count_q;
  logic                 fifo_push, fifo_pop, fifo_empty;
  logic [FifoWidth-1:0] fifo_head;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  assign fifo_push  = in_wr && (count_q != 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  // One slot of slack so a write already in flight when in_rdy drops still fits.
  assign in_rdy     = (count_q < 3'd3);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign head_ctrl  = fifo_head[FifoWidth-1 -: CTRL_WIDTH];
  assign head_data  = fifo_head[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= {in_ctrl, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (fifo_push && !fifo_pop) begin
        count_q <= count_q + 3'd1;
      end else if (!fifo_push && fifo_pop) begin
        count_q <= count_q - 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timestamp: prescaler divides clk by TS_DIV, counter wraps silently.
  // ---------------------------------------------------------------------------
  logic [31:0] ts_pre_q, ts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_pre_q <= 32'd0;
      ts_q     <= 32'd0;
    end else if (ts_pre_q == 32'(TS_DIV - 1)) begin
      ts_pre_q <= 32'd0;
      ts_q     <= ts_q + 32'd1;
    end else begin
      ts_pre_q <= ts_pre_q + 32'd1;
    end
  end

  assign ts_now = ts_q;

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        stamp_q, stamp_d;
  logic [31:0] ts_lat_q, ts_lat_d;
  logic [15:0] seq_q, seq_d;
  logic [DATA_WIDTH-1:0] hdr_patched;
  logic [DATA_WIDTH-1:0] stamp_word;

  assign stamp_word = DATA_WIDTH'({16'h0, seq_q, ts_lat_q});

  always_comb begin
    hdr_patched = head_data;
    hdr_patched[IoqWordLenPos +: 16] = head_data[IoqWordLenPos +: 16] + 16'd1;
    hdr_patched[IoqByteLenPos +: 16] = head_data[IoqByteLenPos +: 16] + 16'd8;
  end

  always_comb begin
    state_d  = state_q;
    stamp_d  = stamp_q;
    ts_lat_d = ts_lat_q;
    seq_d    = seq_q;
    fifo_pop = 1'b0;
    out_wr   = 1'b0;
    out_ctrl = head_ctrl;
    out_data = head_data;
    // Nothing moves unless a word is present and downstream can take it.
    if (!reset && !fifo_empty && out_rdy) begin
      unique case (state_q)
        StHdrs: begin
          if (head_ctrl == IoQueueStageNum) begin
            ts_lat_d = ts_q;
            stamp_d  = stamp_en;
            out_wr   = 1'b1;
            fifo_pop = 1'b1;
            if (stamp_en) out_data = hdr_patched;
          end else if (head_ctrl != '0) begin
            out_wr   = 1'b1;
            fifo_pop = 1'b1;
          end else begin
            // First payload word stays at the head; stamp goes out in its place.
            state_d = StThru;
            if (stamp_q) begin
              out_ctrl = '0;
              out_data = stamp_word;
              out_wr   = 1'b1;
              seq_d    = seq_q + 16'd1;
            end
          end
        end
        StThru: begin
          out_wr   = 1'b1;
          fifo_pop = 1'b1;
          if (head_ctrl != '0) begin
            state_d = StHdrs;
            // Cleared so a following packet without an IOQ header is not stamped.
            stamp_d = 1'b0;
          end
        end
        default: state_d = StHdrs;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StHdrs;
      stamp_q  <= 1'b0;
      ts_lat_q <= 32'd0;
      seq_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      stamp_q  <= stamp_d;
      ts_lat_q <= ts_lat_d;
      seq_q    <= seq_d;
    end
  end

endmodule

// File: doc/probe_ts_stamp.md
Name: probe_ts_stamp

Overview:
- Ingress-side writer of the RTT probe timestamp word, sitting in the user data path ahead of the output queues.
- For every packet, once the module headers have passed, inserts one 64-bit word carrying a 16-bit probe sequence number and the 32-bit ingress timestamp.
- Patches the IOQ header lengths to account for the inserted word.
- The downstream stats block consumes this word (probe traffic) or discards it (regular traffic).

Parameters:
DATA_WIDTH, 64, datapath width; only 64 is supported.
CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
TS_DIV, 1, clk cycles per timestamp tick; must be at least 1.

Ports:
clk  in  1  clock; single clock domain.
reset  in  1  synchronous, active-high reset.
in_data  in  DATA_WIDTH  input word.
in_ctrl  in  CTRL_WIDTH  input ctrl.
in_wr  in  1  input write strobe.
in_rdy  out  1  equals !input-FIFO nearly_full.
out_data  out  DATA_WIDTH  output word.
out_ctrl  out  CTRL_WIDTH  output ctrl.
out_wr  out  1  output write strobe.
out_rdy  in  1  downstream ready.
stamp_en  in  1  stamping enable; sampled only when an IOQ header is accepted.
ts_now  out  32  free-running timestamp counter (debug and visibility).

Behaviour:
- Input buffering: fallthrough_small_fifo, width CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS=2. in_rdy = !nearly_full.
- Outputs are combinational from the FIFO head or the stamp word.
- Output rule: out_wr=1 only when out_rdy=1 and a word is available. Words are never dropped, and at most one word moves per cycle.
- Timestamp counter:
  - ts_now increments by 1 every TS_DIV cycles; prescaler and counter are 0 after reset.
  - 32-bit, wraps 0xFFFFFFFF -> 0 silently.
- Sequence counter: seq[15:0], 0 after reset, +1 per stamped packet, wraps at 0xFFFF -> 0.
- State HDRS (reset state). When FIFO is non-empty and out_rdy=1:
  - FIFO head ctrl == `IO_QUEUE_STAGE_NUM:
    - Latch ts_lat = ts_now and stamp = stamp_en.
    - If stamp=1, forward the header with word length (`IOQ_WORD_LEN_POS, 16 bits) +1 and byte length (`IOQ_BYTE_LEN_POS, 16 bits) +8, both mod 2^16; all other bits unchanged.
    - If stamp=0, forward the header unchanged.
    - Pop the FIFO.
  - Other nonzero ctrl (other module headers): forward unchanged, pop.
  - ctrl == 0 (first payload word):
    - stamp=1: do not pop; emit out_data = {16'h0, seq, ts_lat}, out_ctrl = 0. Increment seq; go to THRU.
    - stamp=0: go to THRU without output that cycle.
  - A packet with no IOQ header is treated as stamp=0.
- State THRU: when FIFO is non-empty and out_rdy=1, forward and pop. If ctrl != 0 (EOP), go to HDRS.
- Back-pressure: out_rdy=0 freezes state, FIFO, ts_lat, stamp and seq. The stamp word is held until accepted. ts_now keeps counting regardless.
- stamp_en changes mid-packet do not affect the packet in flight.
- reset: state -> HDRS, stamp -> 0, counters -> 0, input FIFO cleared, out_wr = 0 in the reset cycle.
  - Reset mid-packet discards the partial packet; the next accepted word is treated as a header.
- Latency: header to output in the same cycle it reaches the FIFO head. Each stamped packet costs one extra output cycle.

Test Plan:
- stamp_en=1, TS_DIV=1; inject at ts_now=0x100 a packet with IOQ hdr (word_len=4, byte_len=30, dst port bit 1), 3 data words, last word ctrl=0x04 -> output header shows word_len=5, byte_len=38; word 2 = 0x0000_0000_0000_0100; data words follow unchanged; EOP ctrl 0x04 preserved; seq becomes 1.
- stamp_en=0, same packet -> output bit-identical to input, 5 words in / 5 out (header + 3 data + EOP), seq stays 0.
- Two module headers (ctrl 0xFF then 0xFE) before data -> stamp word appears after the 0xFE word; 0xFE word unchanged.
- out_rdy held low for 5 cycles while the stamp word is pending, ts_now advancing -> the emitted word carries the ts latched at header acceptance; no duplicate or lost words.
- seq preloaded via 65536 stamped packets -> the next stamp word shows seq=0; header with word_len=0xFFFF -> output 0x0000.
- TS_DIV=4 -> ts_now increments once every 4 cycles. Assert reset after the stamp word is emitted, mid-packet -> next packet is handled from HDRS, with ts and seq restarted at 0.
